// File: rtl/seg7_scan_ctrl.sv
// Scans NUM_DIGITS BCD digits onto one shared 7-segment bus, blanking between digits and
// swapping in new values only at frame start. Optional leading-zero blanking: SEG7_LZB_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 12000,
    parameter int BLANK_CYCLES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              bcd_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start
);

    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_UNLIT  = SEG_ACT_LOW ? 7'h7F : 7'h00;

    typedef enum logic {BLANK, SHOW} state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           digitIdx_q, digitIdx_d;
    logic [CW-1:0]           phaseCnt_q, phaseCnt_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pendingFull_q, pendingFull_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   digEn_q, digEn_d;
    logic                    frameBoundary;
    logic                    loadFire;
    logic                    slotLit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BLANK;
            digitIdx_q <= '0;
            phaseCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            digitIdx_q <= digitIdx_d;
            phaseCnt_q <= phaseCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        digitIdx_d = digitIdx_q;
        phaseCnt_d = phaseCnt_q + 1'b1;
        unique case (state_q)
            BLANK: begin
                if (phaseCnt_q == BLANK_LAST) begin
                    state_d    = SHOW;
                    phaseCnt_d = '0;
                end
            end
            SHOW: begin
                if (phaseCnt_q == SHOW_LAST) begin
                    state_d    = BLANK;
                    phaseCnt_d = '0;
                    digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + 1'b1;
                end
            end
            default: begin
                state_d    = BLANK;
                phaseCnt_d = '0;
            end
        endcase
    end

`ifdef SEG7_LZB_EN
    // A slot is dark when it and every more significant digit are zero; digit 0 never is.
    logic [NUM_DIGITS-1:0] digitShown;

    always_comb begin
        logic upperNonZero;
        upperNonZero = 1'b0;
        digitShown   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upperNonZero  = upperNonZero | (active_q[4*i +: 4] != 4'd0);
            digitShown[i] = upperNonZero || (i == 0);
        end
    end

    assign slotLit = digitShown[digitIdx_d];
`else
    assign slotLit = 1'b1;
`endif

    // Segment and enable registers are loaded from the state being entered, so they
    // switch on exactly the edge that enters SHOW or BLANK.
    always_comb begin
        frameBoundary = (state_q == BLANK) && (digitIdx_q == '0) && (phaseCnt_q == '0);
        seg_d         = SEG_UNLIT;
        digEn_d       = '0;
        if (state_d == SHOW && slotLit) begin
            seg_d   = seg_in ^ SEG_UNLIT;
            digEn_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digitIdx_d;
        end
    end

    assign loadFire = load_valid && !pendingFull_q;

    always_comb begin
        active_d      = active_q;
        pending_d     = pending_q;
        pendingFull_d = pendingFull_q;
        if (frameBoundary && pendingFull_q) begin
            active_d      = pending_q;
            pendingFull_d = 1'b0;
        end else if (loadFire) begin
            pending_d     = load_data;
            pendingFull_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= '0;
            pending_q     <= '0;
            pendingFull_q <= 1'b0;
            seg_q         <= SEG_UNLIT;
            digEn_q       <= '0;
        end else begin
            active_q      <= active_d;
            pending_q     <= pending_d;
            pendingFull_q <= pendingFull_d;
            seg_q         <= seg_d;
            digEn_q       <= digEn_d;
        end
    end

    // Frame start is held low while reset is asserted so the first cycle after release
    // is the only one flagged before the counters start moving.
    assign frame_start = rst_n & frameBoundary;
    assign load_ready  = !pendingFull_q;
    assign bcd_out     = active_q[{digitIdx_q, 2'b00} +: 4];
    assign seg_out     = seg_q;
    assign dig_en      = digEn_q;

endmodule
